mem_port_arbiter: RTL

Shares the single-port word-addressed data RAM between the core's instruction-fetch port and its load/store port, one access per cycle. Data accesses win conflicts by default; a starvation counter forces a fetch grant after a bounded wait. The block sits between `top` and `ram` inside `wrapper`. It owns read-data return routing, so each requester sees a one-cycle `gnt` → `rvalid` handshake.

---
 rtl/mem_port_arbiter.sv | 116 +++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter between instruction fetch and load/store ports.
// Data wins conflicts unless fetch has waited MAX_WAIT cycles; read data is routed back one cycle after grant.
module mem_port_arbiter #(
    parameter int ADDR_W   = 13,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_if_req,
    input  logic [31:0]           i_if_addr,
    output logic                  o_if_gnt,
    output logic                  o_if_rvalid,
    output logic [DATA_W-1:0]     o_if_rdata,
    input  logic                  i_d_req,
    input  logic                  i_d_we,
    input  logic [DATA_W/8-1:0]   i_d_be,
    input  logic [31:0]           i_d_addr,
    input  logic [DATA_W-1:0]     i_d_wdata,
    output logic                  o_d_gnt,
    output logic                  o_d_rvalid,
    output logic [DATA_W-1:0]     o_d_rdata,
    output logic                  o_d_err,
    output logic                  o_mem_en,
    output logic [DATA_W/8-1:0]   o_mem_we,
    output logic [ADDR_W-1:0]     o_mem_addr,
    output logic [DATA_W-1:0]     o_mem_wdata,
    input  logic [DATA_W-1:0]     i_mem_rdata
);

    localparam logic [3:0] MAX_CNT = 4'(MAX_WAIT);

    typedef enum logic [2:0] {
        S_NONE,
        S_IF,
        S_DLD,
        S_DERR,
        S_DST
    } owner_t;

    owner_t     owner, owner_next;
    logic [3:0] starve_cnt, starve_next;
    logic       if_gnt, d_gnt, d_oor;
    logic       unused_addr_bits;

    assign d_oor = |i_d_addr[31:ADDR_W+2];
    assign unused_addr_bits = ^{i_if_addr[31:ADDR_W+2], i_if_addr[1:0], i_d_addr[1:0]};

    // Grants are suppressed while reset is held so the RAM sees no access.
    always_comb begin
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        if (!reset) begin
            if (i_if_req && (!i_d_req || starve_cnt == MAX_CNT)) begin
                if_gnt = 1'b1;
            end else if (i_d_req) begin
                d_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        o_mem_en    = 1'b0;
        o_mem_we    = '0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        if (if_gnt) begin
            o_mem_en   = 1'b1;
            o_mem_addr = i_if_addr[ADDR_W+1:2];
        end else if (d_gnt && !d_oor) begin
            o_mem_en    = 1'b1;
            o_mem_addr  = i_d_addr[ADDR_W+1:2];
            o_mem_wdata = i_d_wdata;
            o_mem_we    = i_d_we ? i_d_be : '0;
        end
    end

    always_comb begin
        owner_next = S_NONE;
        if (if_gnt) begin
            owner_next = S_IF;
        end else if (d_gnt) begin
            if (d_oor)       owner_next = S_DERR;
            else if (i_d_we) owner_next = S_DST;
            else             owner_next = S_DLD;
        end
    end

    always_comb begin
        starve_next = starve_cnt;
        if (!i_if_req || if_gnt) begin
            starve_next = '0;
        end else if (starve_cnt != MAX_CNT) begin
            starve_next = starve_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner      <= S_NONE;
            starve_cnt <= '0;
        end else begin
            owner      <= owner_next;
            starve_cnt <= starve_next;
        end
    end

    assign o_if_gnt    = if_gnt;
    assign o_d_gnt     = d_gnt;
    assign o_if_rvalid = (owner == S_IF);
    assign o_d_rvalid  = (owner == S_DLD);
    assign o_d_err     = (owner == S_DERR);
    assign o_if_rdata  = o_if_rvalid ? i_mem_rdata : '0;
    assign o_d_rdata   = o_d_rvalid ? i_mem_rdata : '0;

endmodule
